// File: rtl/mem_resp_router.sv
// N-slave in-order read response router with a tag FIFO of slave indices.
// Define MEM_ROUTER_REG_OUT_EN to register rdata/rvalid (one extra cycle).
module mem_resp_router #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int NUM_SLAVES   = 2,
  parameter int REGION_SHIFT = 16,
  parameter int DEPTH        = 4,
  localparam int SEL_W       = $clog2(NUM_SLAVES),
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic [SEL_W-1:0]             req_sel,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]        slv_rvalid,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rvalid,
  output logic [CNT_W-1:0]             outstanding,
  output logic                         err_unexpected
);

  logic [SEL_W-1:0]      tags [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [ADDR_W-1:0]     idx;
  logic [SEL_W-1:0]      head;
  logic [NUM_SLAVES-1:0] stray;
  logic [DATA_W-1:0]     head_data;
  logic                  busy;
  logic                  push;
  logic                  pop;
  logic                  err;

  // Addresses past the last region fall into the RAM catch-all
  always_comb begin
    idx = req_addr >> REGION_SHIFT;
    if (idx >= ADDR_W'(NUM_SLAVES))
      req_sel = SEL_W'(NUM_SLAVES - 1);
    else
      req_sel = idx[SEL_W-1:0];
  end

  assign busy        = (count != '0);
  assign req_ready   = (count != CNT_W'(DEPTH));
  assign push        = req_valid && req_ready;
  assign head        = tags[rd_ptr];
  assign pop         = busy && slv_rvalid[head];
  assign outstanding = count;

  always_comb begin
    head_data = '0;
    stray     = slv_rvalid;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (head == SEL_W'(i)) begin
        head_data = slv_rdata[i*DATA_W +: DATA_W];
        if (busy)
          stray[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      tags[wr_ptr] <= req_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (|stray)
        err <= 1'b1;
    end
  end

  assign err_unexpected = err;

`ifdef MEM_ROUTER_REG_OUT_EN
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= pop;
      if (pop)
        rdata_q <= head_data;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`else
  assign rvalid = pop;
  assign rdata  = pop ? head_data : '0;
`endif

endmodule

// File: tb/tb_mem_resp_router.sv
// Directed self-checking bench for mem_resp_router (default parameters).
module tb_mem_resp_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_sel;
  logic [63:0] slv_rdata;
  logic [1:0]  slv_rvalid;
  logic [31:0] rdata;
  logic        rvalid;
  logic [2:0]  outstanding;
  logic        err_unexpected;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_resp_router dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_sel        (req_sel),
    .slv_rdata      (slv_rdata),
    .slv_rvalid     (slv_rvalid),
    .rdata          (rdata),
    .rvalid         (rvalid),
    .outstanding    (outstanding),
    .err_unexpected (err_unexpected)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    slv_rvalid = 2'b00;
  endtask

  task automatic respond(input int s, input logic [31:0] d);
    slv_rvalid    = 2'b00;
    slv_rvalid[s] = 1'b1;
    slv_rdata[s*32 +: 32] = d;
  endtask

  // Call in the cycle the head response is driven; returns after the edge.
  task automatic expect_pop(input string tag, input logic [31:0] d);
    #1;
`ifdef MEM_ROUTER_REG_OUT_EN
    check({tag, "_rv_early"}, {31'd0, rvalid}, 32'd0);
    tick();
    check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check({tag, "_rdata"}, rdata, d);
`else
    check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check({tag, "_rdata"}, rdata, d);
    tick();
`endif
  endtask

  task automatic expect_drop(input string tag);
    #1;
    check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
`ifndef MEM_ROUTER_REG_OUT_EN
    check({tag, "_rdata"}, rdata, 32'd0);
`endif
    tick();
  endtask

  task automatic push(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    slv_rdata  = '0;
    slv_rvalid = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out", {29'd0, outstanding}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", {31'd0, err_unexpected}, 32'd0);

    // single ROM read
    req_addr = 32'h0000_0040;
    #1;
    check("rom_sel", {31'd0, req_sel}, 32'd0);
    push(32'h0000_0040);
    check("rom_out1", {29'd0, outstanding}, 32'd1);
    tick();
    respond(0, 32'hDEAD_BEEF);
    expect_pop("rom", 32'hDEAD_BEEF);
    check("rom_out0", {29'd0, outstanding}, 32'd0);
    check("rom_err", {31'd0, err_unexpected}, 32'd0);

    // mixed order: RAM answers while ROM is head
    push(32'h0000_0100);
    req_addr = 32'h0001_0000;
    #1;
    check("ram_sel", {31'd0, req_sel}, 32'd1);
    push(32'h0001_0000);
    check("mix_out2", {29'd0, outstanding}, 32'd2);
    respond(1, 32'h0000_2222);
    expect_drop("mix_drop");
    check("mix_err", {31'd0, err_unexpected}, 32'd1);
    check("mix_out2b", {29'd0, outstanding}, 32'd2);
    respond(0, 32'h0000_1111);
    expect_pop("mix_rom", 32'h0000_1111);
    respond(1, 32'h0000_3333);
    expect_pop("mix_ram", 32'h0000_3333);
    check("mix_out0", {29'd0, outstanding}, 32'd0);
    check("mix_err_sticky", {31'd0, err_unexpected}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("clr_err", {31'd0, err_unexpected}, 32'd0);

    // fill to DEPTH, refused push, pop, push+pop
    for (int i = 0; i < 4; i++) push(32'h0000_0010 * i);
    check("full_out", {29'd0, outstanding}, 32'd4);
    check("full_ready", {31'd0, req_ready}, 32'd0);
    push(32'h0001_0000);
    check("full_hold", {29'd0, outstanding}, 32'd4);
    respond(0, 32'hA5A5_0001);
    expect_pop("full_pop", 32'hA5A5_0001);
    check("full_out3", {29'd0, outstanding}, 32'd3);
    check("full_ready1", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = 32'h0001_0000;
    respond(0, 32'hA5A5_0002);
    expect_pop("pp_pop", 32'hA5A5_0002);
    check("pp_out3", {29'd0, outstanding}, 32'd3);
    check("pp_err", {31'd0, err_unexpected}, 32'd0);

    // decode clamp and region edges
    req_addr = 32'h8000_0000;
    #1;
    check("clamp_hi", {31'd0, req_sel}, 32'd1);
    req_addr = 32'h0000_FFFF;
    #1;
    check("edge_lo", {31'd0, req_sel}, 32'd0);
    req_addr = 32'h0001_FFFF;
    #1;
    check("edge_hi", {31'd0, req_sel}, 32'd1);

    // reset with 3 outstanding, then a late response
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out", {29'd0, outstanding}, 32'd0);
    check("mrst_rvalid", {31'd0, rvalid}, 32'd0);
    check("mrst_err0", {31'd0, err_unexpected}, 32'd0);
    respond(0, 32'h0BAD_0BAD);
    expect_drop("late");
    check("late_err", {31'd0, err_unexpected}, 32'd1);
    check("late_out", {29'd0, outstanding}, 32'd0);

    // response in the push cycle sees the empty pre-push FIFO
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0004;
    respond(0, 32'h1234_5678);
    expect_drop("same_cyc");
    check("same_out", {29'd0, outstanding}, 32'd1);
    check("same_err", {31'd0, err_unexpected}, 32'd1);
    respond(0, 32'h8765_4321);
    expect_pop("same_next", 32'h8765_4321);
    check("same_out0", {29'd0, outstanding}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_resp_router.md
Name: mem_resp_router

Overview:
- Parametrised N-slave memory read router; successor to the two-way ROM/RAM read mux.
- Decodes each read request address to a slave index and records that index in an in-order tag FIFO.
- Returns read data only from the slave at the FIFO head, so multiple reads can be outstanding across slaves with different latencies.
- Sits between the core load/fetch port and the ROM/RAM/peripheral read responders.

Parameters:
DATA_W, 32, read data width
ADDR_W, 32, request address width
NUM_SLAVES, 2, number of responders (2..8); slave 0 = ROM
REGION_SHIFT, 16, low address bits ignored by decode; slave index = addr >> REGION_SHIFT
DEPTH, 4, maximum outstanding reads (power of 2, >= 2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  read request present
req_ready  out  1  router can accept a request
req_addr  in  ADDR_W  request address
req_sel  out  SEL_W=clog2(NUM_SLAVES)  decoded slave index of req_addr (combinational), used to steer the request
slv_rdata  in  NUM_SLAVES*DATA_W  packed slave read data; slave i at [i*DATA_W +: DATA_W]
slv_rvalid  in  NUM_SLAVES  per-slave read-valid pulse
rdata  out  DATA_W  routed read data
rvalid  out  1  routed read-valid
outstanding  out  clog2(DEPTH)+1  current FIFO occupancy
err_unexpected  out  1  sticky protocol-error flag

Behaviour:
- Decode: idx = req_addr >> REGION_SHIFT. If idx >= NUM_SLAVES, req_sel = NUM_SLAVES-1 (RAM catch-all). Example: addr <= 0x0000_FFFF -> 0; any higher address with NUM_SLAVES=2 -> 1.
- Accept: req_ready = (outstanding != DEPTH). Push req_sel into FIFO when req_valid && req_ready. No full bypass.
- Head: head = FIFO[rd_ptr], valid only when outstanding > 0.
- Pop: when outstanding > 0 && slv_rvalid[head], output slave head's data and advance rd_ptr.
- Simultaneous push and pop: occupancy unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- A request pushed in cycle N cannot be completed before cycle N+1; slv_rvalid in the push cycle is evaluated against the pre-push head.
- Unexpected response: any slv_rvalid[i] with outstanding==0, or i != head. Set err_unexpected (sticky, cleared only by rst) and discard the data. A legal head pop in the same cycle still completes.
- Output timing, combinational mode: rvalid = pop condition, rdata = head slave data, zero added latency. When rvalid=0, rdata = 0.
- Reset: outstanding = 0, pointers = 0, rvalid = 0, rdata = 0, err_unexpected = 0, req_ready = 1 in the cycle after rst.
- Reset mid-operation: all in-flight tags are dropped. Late slave responses after reset count as unexpected.

Optional Feature:
- MEM_ROUTER_REG_OUT_EN defined: rdata and rvalid are registered.
  - Pop in cycle N appears at the output in cycle N+1.
  - Both outputs reset to 0; rdata holds its last value when rvalid=0.
  - Pop, pointer and err logic are unchanged.
- Not defined: combinational output as described above.

Test Plan:
- Single ROM read: req_addr=0x0000_0040, slave0 rvalid 2 cycles later with 0xDEAD_BEEF -> req_sel=0, rvalid=1 with rdata=0xDEAD_BEEF in that same cycle, outstanding 1->0.
- Mixed order: request ROM (0x100), then RAM (0x0001_0000); RAM responds first with 0x2222 while ROM is still pending -> err_unexpected=1, RAM data dropped. Then ROM responds 0x1111 -> rvalid with rdata=0x1111.
- Full: DEPTH=4, four requests with no responses -> req_ready=0, outstanding=4. One head response -> req_ready=1 next cycle. Simultaneous push+pop -> outstanding stays at 3.
- Clamp: NUM_SLAVES=2, req_addr=0x8000_0000 -> req_sel=1.
- Reset with 3 outstanding, then slave0 rvalid -> after rst: outstanding=0, rvalid=0, then err_unexpected=1.
- MEM_ROUTER_REG_OUT_EN: repeat the single ROM read -> rvalid/rdata appear exactly one cycle later than in combinational mode.
